divider_rate_ctrl: RTL and testbench

- Rate controller for the board's clock-divider function. Owns a free-running counter and a 2-bit rate select, and emits a single-cycle `tick` enable at the selected rate; downstream logic uses `tick` as a clock enable on `CLK`.
- Rate changes come from user pulses (`inc`/`dec`) or from an automatic sweep. A change is applied only on a tick boundary, so no tick is shortened, duplicated or spurious.

---
 rtl/divider_rate_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_divider_rate_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_rate_ctrl.sv
// divider_rate_ctrl
//   Rate controller for the clock-divider function. A free-running counter
//   feeds a 2-bit rate select. The rising edge of the selected counter bit
//   produces a one-cycle `tick` that downstream logic uses as a clock enable
//   on CLK. Rate changes come from manual inc/dec pulses or from an automatic
//   sweep. They are applied only on a tick boundary, so no tick is
//   shortened, duplicated or spurious.
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   inc      in   single-cycle request: rate code +1 (saturating)
//   dec      in   single-cycle request: rate code -1 (saturating)
//   auto_en  in   level, 1 = automatic sweep, 0 = manual
//   sel      out  current rate code (00=bit0, 01=BIT_SLOW, 10=BIT_MID, 11=BIT_FAST)
//   tick     out  one-cycle pulse per rising edge of the selected counter bit
//   pending  out  a manual change is latched and waits for the next tick
module divider_rate_ctrl #(
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned BIT_SLOW = 23,
    parameter int unsigned BIT_MID  = 21,
    parameter int unsigned BIT_FAST = 10,
    parameter int unsigned DWELL    = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       inc,
    input  logic       dec,
    input  logic       auto_en,
    output logic [1:0] sel,
    output logic       tick,
    output logic       pending
);

    localparam int unsigned     DW_W       = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    // Dwell count value at which the next tick completes the dwell period.
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        PEND   = 2'd1,
        AUTO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        target_q;
    logic              prev_bit_q;
    logic              tick_q;
    logic [DW_W-1:0]   dwell_q;

    logic              cur_bit;
    logic              fire;
    logic              req_up, req_dn;
    logic              step_ok;
    logic [1:0]        target_base, target_new;

    // FSM output strobes
    logic              ld_target;
    logic              apply;
    logic              auto_adv;
    logic              dwell_inc;
    logic              sel_chg;

    // Counter bit selected by a given rate code.
    function automatic logic rate_bit(input logic [1:0] code,
                                      input logic [CNT_W-1:0] c);
        logic b;
        case (code)
            2'b00:   b = c[0];
            2'b01:   b = c[BIT_SLOW];
            2'b10:   b = c[BIT_MID];
            default: b = c[BIT_FAST];
        endcase
        return b;
    endfunction

    //--------------------------------------------------------------------
    // Edge detect and request decode
    //--------------------------------------------------------------------
    always_comb begin
        cur_bit = rate_bit(sel_q, cnt_q);
        fire    = cur_bit & ~prev_bit_q;
        req_up  = inc & ~dec;
        req_dn  = dec & ~inc;
        // A second request while a change is pending steps from the latched
        // target, so the last request wins and only one switch happens.
        target_base = (state_q == PEND) ? target_q : sel_q;
        step_ok     = (req_up && (target_base != 2'b11)) ||
                      (req_dn && (target_base != 2'b00));
        target_new  = req_up ? (target_base + 2'd1) : (target_base - 2'd1);
    end

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next-state logic. auto_en takes priority over manual requests
    // and over a pending change.
    //--------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            MANUAL: begin
                if (auto_en) begin
                    state_d = AUTO;
                end else if (step_ok) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (auto_en) begin
                    state_d = AUTO;
                end else if (fire) begin
                    state_d = MANUAL;
                end
            end
            AUTO: begin
                if (!auto_en) begin
                    state_d = MANUAL;
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: output / strobe logic
    //--------------------------------------------------------------------
    always_comb begin
        pending   = 1'b0;
        ld_target = 1'b0;
        apply     = 1'b0;
        auto_adv  = 1'b0;
        dwell_inc = 1'b0;
        case (state_q)
            MANUAL: begin
                ld_target = ~auto_en & step_ok;
            end
            PEND: begin
                pending   = 1'b1;
                ld_target = ~auto_en & step_ok;
                apply     = ~auto_en & fire;
            end
            AUTO: begin
                auto_adv  = auto_en & fire & (dwell_q == DWELL_LAST);
                dwell_inc = auto_en & fire & (dwell_q != DWELL_LAST);
            end
            default: ;
        endcase
    end

    //--------------------------------------------------------------------
    // Next rate code
    //--------------------------------------------------------------------
    always_comb begin
        sel_d = sel_q;
        if (apply) begin
            // A request arriving on the tick itself is folded in.
            sel_d = ld_target ? target_new : target_q;
        end else if (auto_adv) begin
            sel_d = sel_q + 2'd1;
        end
    end

    assign sel_chg = apply | auto_adv;

    //--------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q      <= '0;
            sel_q      <= 2'b01;
            target_q   <= 2'b01;
            prev_bit_q <= 1'b0;
            tick_q     <= 1'b0;
            dwell_q    <= '0;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= fire;
            sel_q  <= sel_d;
            // On a rate switch the edge detector is primed with the new
            // bit's current value, so a new bit that is already high cannot
            // produce a false tick. The first tick at the new rate is the
            // next true 0->1 of the new bit.
            prev_bit_q <= sel_chg ? rate_bit(sel_d, cnt_q) : cur_bit;
            if (ld_target) begin
                target_q <= target_new;
            end
            if (dwell_inc) begin
                dwell_q <= dwell_q + DW_W'(1);
            end else if (auto_adv || (state_q != AUTO) || !auto_en) begin
                dwell_q <= '0;
            end
        end
    end

    assign sel  = sel_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_divider_rate_ctrl.sv
module tb_divider_rate_ctrl;

    localparam int CW     = 8;
    localparam int B_SLOW = 6;
    localparam int B_MID  = 4;
    localparam int B_FAST = 2;
    localparam int DWELL  = 2;

    logic       CLK;
    logic       RST_N;
    logic       inc;
    logic       dec;
    logic       auto_en;
    logic [1:0] sel;
    logic       tick;
    logic       pending;

    divider_rate_ctrl #(
        .CNT_W   (CW),
        .BIT_SLOW(B_SLOW),
        .BIT_MID (B_MID),
        .BIT_FAST(B_FAST),
        .DWELL   (DWELL)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .inc    (inc),
        .dec    (dec),
        .auto_en(auto_en),
        .sel    (sel),
        .tick   (tick),
        .pending(pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model state: counter value, rate code, mode, latched request.
    int m_cnt, m_sel, m_auto, m_pend, m_target, m_dwell, m_tick;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, got, exp);
        end
    endtask

    function automatic int kbit(input int s);
        case (s)
            0:       return 0;
            1:       return B_SLOW;
            2:       return B_MID;
            default: return B_FAST;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sel = 1; m_auto = 0; m_pend = 0;
        m_target = 1; m_dwell = 0; m_tick = 0;
    endtask

    // One clock of the rules: bit k of a +1 counter rises exactly when the
    // counter value is congruent to 2^k modulo 2^(k+1).
    task automatic model_step(input logic i, input logic d, input logic a);
        int  per, base, nt;
        logic f, was_pend;
        per      = 2 << kbit(m_sel);
        f        = ((m_cnt % per) == (per / 2));
        was_pend = (m_pend != 0);
        if (m_auto != 0) begin
            if (!a) begin
                m_auto = 0; m_dwell = 0;
            end else if (f) begin
                m_dwell++;
                if (m_dwell == DWELL) begin
                    m_sel = (m_sel + 1) % 4; m_dwell = 0;
                end
            end
        end else if (a) begin
            m_auto = 1; m_pend = 0; m_dwell = 0;
        end else begin
            if (i != d) begin
                base = was_pend ? m_target : m_sel;
                nt   = i ? base + 1 : base - 1;
                if (nt >= 0 && nt <= 3) begin
                    m_target = nt; m_pend = 1;
                end
            end
            if (was_pend && f) begin
                m_sel = m_target; m_pend = 0;
            end
        end
        m_tick = f;
        m_cnt  = (m_cnt + 1) % (1 << CW);
    endtask

    // Apply inputs for one clock, advance the model, compare after the edge.
    task automatic cyc(input logic i, input logic d, input logic a);
        inc = i; dec = d; auto_en = a;
        model_step(i, d, a);
        @(posedge CLK);
        #1;
        edge_n++;
        check("sel", sel, m_sel);
        check("pending", pending, m_pend);
        check("tick", tick, m_tick);
    endtask

    // Assert reset mid-cycle and check the outputs clear before any edge.
    task automatic apply_reset();
        @(negedge CLK);
        inc = 1'b0; dec = 1'b0; auto_en = 1'b0;
        RST_N = 1'b0;
        #1;
        check("rst_sel", sel, 2'b01);
        check("rst_pending", pending, 1'b0);
        check("rst_tick", tick, 1'b0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        edge_n = 0;
    endtask

    typedef struct {
        logic       i;
        logic       d;
        logic       a;
        int         n;
        logic [1:0] esel;
        logic       epend;
    } vec_t;

    vec_t vt[13];

    initial begin
        int   tq[$];
        int   cq[$];
        int   sq[$];
        int   pend_seen;
        int   first_tick;
        logic [1:0] last_sel;
        logic ra;

        RST_N = 1'b1; inc = 1'b0; dec = 1'b0; auto_en = 1'b0;
        model_reset();

        // Manual-mode vectors from reset: {inc, dec, auto_en, edges, sel, pending}.
        // Inputs are held for the first edge only. Edge numbers count from
        // reset release, and edge e samples counter value e-1.
        vt[0]  = '{1'b0, 1'b0, 1'b0, 10, 2'b01, 1'b0};  // edges 1..10 idle
        vt[1]  = '{1'b1, 1'b0, 1'b0,  1, 2'b01, 1'b1};  // edge 11 inc -> pending
        vt[2]  = '{1'b0, 1'b0, 1'b0, 53, 2'b01, 1'b1};  // edges 12..64 waiting
        vt[3]  = '{1'b0, 1'b0, 1'b0,  1, 2'b10, 1'b0};  // edge 65 tick -> switch
        vt[4]  = '{1'b1, 1'b0, 1'b0,  1, 2'b10, 1'b1};  // edge 66 inc
        vt[5]  = '{1'b0, 1'b0, 1'b0, 14, 2'b10, 1'b1};  // edges 67..80
        vt[6]  = '{1'b0, 1'b0, 1'b0,  1, 2'b11, 1'b0};  // edge 81 tick -> 11
        vt[7]  = '{1'b1, 1'b0, 1'b0,  1, 2'b11, 1'b0};  // edge 82 inc saturated
        vt[8]  = '{1'b0, 1'b1, 1'b0,  1, 2'b11, 1'b1};  // edge 83 dec
        vt[9]  = '{1'b0, 1'b1, 1'b0,  1, 2'b11, 1'b1};  // edge 84 second dec
        vt[10] = '{1'b0, 1'b0, 1'b0,  1, 2'b01, 1'b0};  // edge 85 tick -> 01
        vt[11] = '{1'b1, 1'b1, 1'b0,  1, 2'b01, 1'b0};  // edge 86 inc&dec ignored
        vt[12] = '{1'b0, 1'b0, 1'b0, 20, 2'b01, 1'b0};  // edges 87..106

        // Idle at the reset rate: ticks every 128 cycles, never pending.
        apply_reset();
        pend_seen = 0;
        for (int n = 0; n < 300; n++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (tick) tq.push_back(edge_n);
            if (pending) pend_seen++;
        end
        check("idle_tick_count", tq.size(), 2);
        check("idle_first_tick", (tq.size() > 0) ? tq[0] : -1, 65);
        check("idle_period", (tq.size() > 1) ? tq[1] - tq[0] : -1, 128);
        check("idle_pending", pend_seen, 0);

        // Manual requests, saturation, double request, simultaneous inc&dec.
        apply_reset();
        for (int v = 0; v < 13; v++) begin
            cyc(vt[v].i, vt[v].d, vt[v].a);
            for (int r = 1; r < vt[v].n; r++) cyc(1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_sel", v), sel, vt[v].esel);
            check($sformatf("vec%0d_pending", v), pending, vt[v].epend);
        end

        // Auto sweep from 01 with stray inc/dec pulses.
        apply_reset();
        tq.delete();
        last_sel = sel;
        for (int n = 0; n < 330; n++) begin
            if (n == 0) cyc(1'b0, 1'b0, 1'b1);
            else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'b1);
            if (tick) tq.push_back(edge_n);
            if (sel != last_sel) begin
                cq.push_back(edge_n);
                sq.push_back(int'(sel));
                last_sel = sel;
            end
        end
        check("auto_changes", cq.size(), 4);
        if (cq.size() == 4) begin
            check("auto_chg0_edge", cq[0], 193); check("auto_chg0_sel", sq[0], 2);
            check("auto_chg1_edge", cq[1], 241); check("auto_chg1_sel", sq[1], 3);
            check("auto_chg2_edge", cq[2], 253); check("auto_chg2_sel", sq[2], 0);
            check("auto_chg3_edge", cq[3], 256); check("auto_chg3_sel", sq[3], 1);
        end
        check("auto_tick_count", tq.size(), 9);
        if (tq.size() == 9) begin
            check("auto_t1", tq[1], 193);
            check("auto_t_mid", tq[3] - tq[2], 32);
            check("auto_t_fast", tq[5] - tq[4], 8);
            check("auto_t_bit0", tq[7] - tq[6], 2);
            check("auto_t_wrap", tq[8], 321);
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("auto_exit_sel", sel, 2'b01);
        check("auto_exit_pending", pending, 1'b0);

        // Reset while a change is pending.
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("pend_before_reset", pending, 1'b1);
        apply_reset();
        first_tick = -1;
        for (int n = 0; n < 200 && first_tick < 0; n++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (tick) first_tick = edge_n;
        end
        check("post_reset_first_tick", first_tick, 65);

        // Randomized traffic against the model.
        apply_reset();
        ra = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) ra = ~ra;
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, ra);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "timeout");
    end

endmodule
